// File: rtl/spi_ram_slave_p.sv
// SPI slave with an integrated single-port RAM: framed write-address/write-data/
// read-address/read-data commands, optional pointer auto-increment, frame-error pulse.
module spi_ram_slave_p #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter bit          AUTO_INC = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic frame_err,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] OUT_END  = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, SHIFT_OUT, DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W:0]     sh_in;
    logic [DATA_W-1:0]   sh_out;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_valid;
    logic                err_pend;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic [DATA_W+1:0]   frame;
    logic [1:0]          cmd;
    logic [DATA_W-1:0]   payload;
    logic                cmd_ok;
    logic                mem_we;

    // frame includes the bit being sampled this edge, so the commit sees the whole word
    always_comb begin
        frame   = {sh_in, mosi};
        cmd     = frame[DATA_W+1:DATA_W];
        payload = frame[DATA_W-1:0];
        cmd_ok  = 1'b0;
        case (state)
            WRITE:     cmd_ok = ~cmd[1];
            READ_ADD:  cmd_ok = (cmd == 2'b10);
            READ_DATA: cmd_ok = (cmd == 2'b11);
            default:   cmd_ok = 1'b0;
        endcase
        mem_we = !rst && !ss_n && (state == WRITE) && (bit_cnt == LAST_BIT) && (cmd == 2'b01);
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_addr] <= payload;
    end

    assign busy = (state != IDLE);

    // frame_err is delayed one edge through err_pend so it rises on the edge after the fault
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sh_in     <= '0;
            sh_out    <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            rd_valid  <= 1'b0;
            err_pend  <= 1'b0;
            miso      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_pend;
            err_pend  <= 1'b0;
            if (state != IDLE && state != DONE && ss_n) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                miso     <= 1'b0;
                err_pend <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (!ss_n)
                            state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        bit_cnt <= '0;
                        if (!mosi)
                            state <= WRITE;
                        else if (!rd_valid)
                            state <= READ_ADD;
                        else
                            state <= READ_DATA;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        sh_in <= frame[DATA_W:0];
                        if (bit_cnt != LAST_BIT) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else begin
                            bit_cnt <= '0;
                            state   <= DONE;
                            if (!cmd_ok) begin
                                err_pend <= 1'b1;
                            end else begin
                                case (cmd)
                                    2'b00: wr_addr <= payload[ADDR_W-1:0];
                                    2'b01: if (AUTO_INC) wr_addr <= wr_addr + ADDR_W'(1);
                                    2'b10: begin
                                        rd_addr  <= payload[ADDR_W-1:0];
                                        rd_valid <= 1'b1;
                                    end
                                    default: begin
                                        sh_out <= mem[rd_addr];
                                        state  <= SHIFT_OUT;
                                        if (AUTO_INC) rd_addr <= rd_addr + ADDR_W'(1);
                                    end
                                endcase
                            end
                        end
                    end
                    SHIFT_OUT: begin
                        if (bit_cnt == OUT_END) begin
                            miso    <= 1'b0;
                            bit_cnt <= '0;
                            state   <= DONE;
                            if (!AUTO_INC) rd_valid <= 1'b0;
                        end else begin
                            miso    <= sh_out[DATA_W-1];
                            sh_out  <= {sh_out[DATA_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    DONE: begin
                        if (ss_n)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Table-driven bench for spi_ram_slave_p: three parameterisations share clk/rst,
// only the selected instance sees ss_n low.
module tb_spi_ram_slave_p;

    logic clk = 1'b0;
    logic rst, ss_n, mosi;
    int   sel;
    logic ss_n0, ss_n1, ss_n2;
    logic miso0, miso1, miso2, err0, err1, err2, busy0, busy1, busy2;
    logic miso_m, err_m, busy_m;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    assign ss_n0 = (sel == 0) ? ss_n : 1'b1;
    assign ss_n1 = (sel == 1) ? ss_n : 1'b1;
    assign ss_n2 = (sel == 2) ? ss_n : 1'b1;

    always_comb begin
        case (sel)
            0:       begin miso_m = miso0; err_m = err0; busy_m = busy0; end
            1:       begin miso_m = miso1; err_m = err1; busy_m = busy1; end
            default: begin miso_m = miso2; err_m = err2; busy_m = busy2; end
        endcase
    end

    spi_ram_slave_p #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1'b0)) u_d8_static (
        .clk(clk), .rst(rst), .ss_n(ss_n0), .mosi(mosi),
        .miso(miso0), .frame_err(err0), .busy(busy0));
    spi_ram_slave_p #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1'b1)) u_d8_inc (
        .clk(clk), .rst(rst), .ss_n(ss_n1), .mosi(mosi),
        .miso(miso1), .frame_err(err1), .busy(busy1));
    spi_ram_slave_p #(.DATA_W(16), .ADDR_W(4), .AUTO_INC(1'b0)) u_d16 (
        .clk(clk), .rst(rst), .ss_n(ss_n2), .mosi(mosi),
        .miso(miso2), .frame_err(err2), .busy(busy2));

    typedef struct {
        int          sel;
        bit          s;
        logic [1:0]  cmd;
        logic [15:0] pay;
        int          n_low;     // edge index at which ss_n is first seen high
        int          rst_edge;  // -1: no reset
        bit          chk_rd;
        logic [15:0] exp_rd;
        int          exp_err;   // edge index of frame_err pulse, -1: none
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input int sl, input bit s, input logic [1:0] c, input logic [15:0] p,
                       input int n, input int re, input bit chk, input logic [15:0] rdv,
                       input int ee);
        vec_t v;
        v.sel = sl; v.s = s; v.cmd = c; v.pay = p; v.n_low = n; v.rst_edge = re;
        v.chk_rd = chk; v.exp_rd = rdv; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int dw = (v.sel == 2) ? 16 : 8;
        int e_last = dw + 3;
        logic [15:0] rd = '0;
        int err_cnt = 0;
        int err_edge = -1;
        int miso_bad = 0;
        bit rd_frame = v.chk_rd || (v.rst_edge >= 0);
        int j;
        sel = v.sel;
        @(negedge clk);
        ss_n = 1'b0;
        mosi = 1'b0;
        for (int e = 0; e < v.n_low + 3; e++) begin
            @(negedge clk);
            if (err_m === 1'b1) begin err_cnt++; err_edge = e; end
            if (rd_frame && e >= e_last + 1 && e <= e_last + dw &&
                (v.rst_edge < 0 || e < v.rst_edge))
                rd = {rd[14:0], miso_m};
            else if (miso_m !== 1'b0)
                miso_bad++;
            if (e == v.rst_edge)
                check($sformatf("v%0d busy_after_rst", idx), {31'd0, busy_m}, 32'd0);
            rst  = (e + 1 == v.rst_edge);
            ss_n = (e + 1 >= v.n_low) || (v.rst_edge >= 0 && e + 1 >= v.rst_edge);
            if (e + 1 == 1) begin
                mosi = v.s;
            end else if (e + 1 >= 2 && e + 1 <= e_last) begin
                j = e + 1 - 2;
                if (j == 0)      mosi = v.cmd[1];
                else if (j == 1) mosi = v.cmd[0];
                else             mosi = v.pay[dw + 1 - j];
            end else begin
                mosi = 1'b0;
            end
        end
        check($sformatf("v%0d err_count", idx), err_cnt, (v.exp_err < 0) ? 0 : 1);
        check($sformatf("v%0d err_edge", idx), err_edge, v.exp_err);
        check($sformatf("v%0d miso_idle_zero", idx), miso_bad, 0);
        check($sformatf("v%0d busy_end", idx), {31'd0, busy_m}, 32'd0);
        if (v.chk_rd)
            check($sformatf("v%0d read_word", idx), {16'd0, rd}, {16'd0, v.exp_rd});
    endtask

    initial begin
        // 8-bit, static pointers: E=11, full frame ss_n high at 12, readout at 21
        add(0, 0, 2'b00, 16'h00FC, 12, -1, 0, 16'h0,    -1);
        add(0, 0, 2'b01, 16'h00B1, 12, -1, 0, 16'h0,    -1);
        add(0, 1, 2'b10, 16'h00FC, 12, -1, 0, 16'h0,    -1);
        add(0, 1, 2'b11, 16'h00BC, 21, -1, 1, 16'h00B1, -1);
        add(0, 1, 2'b11, 16'h0000, 12, -1, 0, 16'h0,    12);  // rd_valid cleared -> READ_ADD
        add(0, 0, 2'b11, 16'h0055, 12, -1, 0, 16'h0,    12);  // illegal in WRITE
        add(0, 0, 2'b10, 16'h0077, 12, -1, 0, 16'h0,    12);
        add(0, 1, 2'b00, 16'h0012, 12, -1, 0, 16'h0,    12);  // illegal in READ_ADD
        add(0, 1, 2'b10, 16'h00FC, 12, -1, 0, 16'h0,    -1);
        add(0, 1, 2'b11, 16'h0000, 21, -1, 1, 16'h00B1, -1);
        add(0, 0, 2'b01, 16'h003C, 12, -1, 0, 16'h0,    -1);
        add(0, 0, 2'b01, 16'h00E7,  9, -1, 0, 16'h0,    10);  // abort after 5 payload bits
        add(0, 1, 2'b10, 16'h00FC, 12, -1, 0, 16'h0,    -1);
        add(0, 1, 2'b11, 16'h0000, 21, -1, 1, 16'h003C, -1);
        // 8-bit, auto-increment burst with wrap
        add(1, 0, 2'b00, 16'h00FE, 12, -1, 0, 16'h0,    -1);
        add(1, 0, 2'b01, 16'h0011, 12, -1, 0, 16'h0,    -1);
        add(1, 0, 2'b01, 16'h0022, 12, -1, 0, 16'h0,    -1);
        add(1, 0, 2'b01, 16'h0033, 12, -1, 0, 16'h0,    -1);
        add(1, 0, 2'b01, 16'h00E7,  9, -1, 0, 16'h0,    10);
        add(1, 0, 2'b01, 16'h0044, 12, -1, 0, 16'h0,    -1);
        add(1, 1, 2'b10, 16'h00FE, 12, -1, 0, 16'h0,    -1);
        add(1, 1, 2'b11, 16'h0000, 21, -1, 1, 16'h0011, -1);
        add(1, 1, 2'b11, 16'h0000, 21, -1, 1, 16'h0022, -1);
        add(1, 1, 2'b11, 16'h0000, 21, -1, 1, 16'h0033, -1);
        add(1, 1, 2'b11, 16'h0000, 21, -1, 1, 16'h0044, -1);
        add(1, 1, 2'b11, 16'h0000, 21, 15, 0, 16'h0,    -1);  // reset during SHIFT_OUT
        add(1, 1, 2'b11, 16'h0000, 12, -1, 0, 16'h0,    12);  // rd_valid was reset
        add(1, 1, 2'b10, 16'h0000, 12, -1, 0, 16'h0,    -1);
        add(1, 1, 2'b11, 16'h0000, 21, -1, 1, 16'h0033, -1);  // RAM survives reset
        // 16-bit data, 4-bit address: E=19, full frame 20, readout 37
        add(2, 0, 2'b00, 16'hFFF3, 20, -1, 0, 16'h0,    -1);
        add(2, 0, 2'b01, 16'hA5C3, 20, -1, 0, 16'h0,    -1);
        add(2, 0, 2'b00, 16'h0004, 20, -1, 0, 16'h0,    -1);
        add(2, 0, 2'b01, 16'h1234, 20, -1, 0, 16'h0,    -1);
        add(2, 1, 2'b10, 16'hABC3, 20, -1, 0, 16'h0,    -1);
        add(2, 1, 2'b11, 16'h0000, 37, -1, 1, 16'hA5C3, -1);
        add(2, 0, 2'b11, 16'hFFFF, 20, -1, 0, 16'h0,    20);
        add(2, 1, 2'b10, 16'h0014, 20, -1, 0, 16'h0,    -1);
        add(2, 1, 2'b11, 16'h0000, 37, -1, 1, 16'h1234, -1);
        add(2, 1, 2'b10, 16'h0003, 20, -1, 0, 16'h0,    -1);
        add(2, 1, 2'b11, 16'h0000, 37, -1, 1, 16'hA5C3, -1);

        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        check("reset miso0", {31'd0, miso0}, 32'd0);
        check("reset miso1", {31'd0, miso1}, 32'd0);
        check("reset miso2", {31'd0, miso2}, 32'd0);
        check("reset err0",  {31'd0, err0},  32'd0);
        check("reset err1",  {31'd0, err1},  32'd0);
        check("reset err2",  {31'd0, err2},  32'd0);
        check("reset busy0", {31'd0, busy0}, 32'd0);
        check("reset busy1", {31'd0, busy1}, 32'd0);
        check("reset busy2", {31'd0, busy2}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
